// File: rtl/mulaw_pkg.sv
// Shared types for the mu-law frame packer: codec config, FSM states and the
// packed FIFO word macro (MULAW_PACK_WORD_T).
`ifndef MULAW_PKG_SV
`define MULAW_PKG_SV

package mulaw_pkg;

    typedef struct packed {
        int unsigned P_ENCODED_DW;
        int unsigned P_DECODED_DW;
    } mu_law_t;

    localparam mu_law_t parameter_mu_law_g711_t = '{P_ENCODED_DW: 8, P_DECODED_DW: 14};

    typedef enum logic {
        S_IDLE,
        S_FILL
    } mulaw_pack_st_e;

endpackage

// Word type depends on the instantiating module's width, so it is stamped out per module.
`define MULAW_PACK_WORD_T(name, dw) \
    typedef struct packed { \
        logic            sof; \
        logic            eof; \
        logic [(dw)-1:0] data; \
    } name;

`endif

// File: rtl/mulaw_pack_fifo.sv
// Single-clock show-ahead word FIFO with registered full/empty flags.
module mulaw_pack_fifo #(
    parameter int P_W     = 34,
    parameter int P_DEPTH = 8
) (
    input  logic           i_clk,
    input  logic           i_rst_n,
    input  logic           i_push,
    input  logic [P_W-1:0] i_dt,
    input  logic           i_pop,
    output logic [P_W-1:0] o_dt,
    output logic           o_full,
    output logic           o_empty
);

    localparam int         AW      = $clog2(P_DEPTH);
    localparam logic [AW:0] DEPTH_C = P_DEPTH[AW:0];
    localparam logic [AW:0] ONE_C   = 1;

    logic [P_W-1:0] mem [P_DEPTH];
    logic [AW-1:0]  wr_ptr;
    logic [AW-1:0]  rd_ptr;
    logic [AW:0]    count;
    logic [AW:0]    count_n;
    logic           wr_en;
    logic           rd_en;

    // A pop on a full FIFO frees the slot the same-cycle push lands in.
    assign rd_en = i_pop && !o_empty;
    assign wr_en = i_push && (!o_full || rd_en);
    assign o_dt  = mem[rd_ptr];

    // NOTE: always_comb assigns every output a default first so no path leaves it unassigned (no latch).
    always_comb begin
        count_n = count;
        if (wr_en && !rd_en)
            count_n = count + ONE_C;
        else if (!wr_en && rd_en)
            count_n = count - ONE_C;
    end

    always_ff @(posedge i_clk) begin
        if (!i_rst_n) begin
            wr_ptr  <= '0;
            rd_ptr  <= '0;
            count   <= '0;
            o_full  <= 1'b0;
            o_empty <= 1'b1;
        end else begin
            if (wr_en) wr_ptr <= wr_ptr + 1'b1;
            if (rd_en) rd_ptr <= rd_ptr + 1'b1;
            count   <= count_n;
            o_full  <= (count_n == DEPTH_C);
            o_empty <= (count_n == '0);
        end
    end

    // NOTE: storage is not reset; only pointers/flags are, and empty slots are never shown as valid.
    always_ff @(posedge i_clk) begin
        if (wr_en) mem[wr_ptr] <= i_dt;
    end

endmodule

// File: rtl/mulaw_frame_packer.sv
// Packs strobed mu-law samples into framed words behind a FIFO; drops whole words on overflow.
// Optional MULAW_PACK_DROP_CNT_EN adds a saturating dropped-word counter port o_drop_cnt.
module mulaw_frame_packer
    import mulaw_pkg::*;
#(
    parameter mu_law_t cfg_t        = parameter_mu_law_g711_t,
    parameter int      P_SPW        = 4,
    parameter int      P_FRAME_WDS  = 40,
    parameter int      P_FIFO_DEPTH = 8,
    parameter logic [cfg_t.P_ENCODED_DW-1:0] P_IDLE_CODE = '1
) (
    input  logic                                  i_clk,
    input  logic                                  i_rst_n,
    input  logic [cfg_t.P_ENCODED_DW-1:0]         i_dt,
    input  logic                                  i_enable,
    input  logic                                  i_flush,
    output logic [P_SPW*cfg_t.P_ENCODED_DW-1:0]   o_dt,
    output logic                                  o_sof,
    output logic                                  o_eof,
    output logic                                  o_valid,
    input  logic                                  i_ready,
    output logic                                  o_ovf
`ifdef MULAW_PACK_DROP_CNT_EN
    ,output logic [15:0]                          o_drop_cnt
`endif
);

    localparam int SW = int'(cfg_t.P_ENCODED_DW);
    localparam int DW = P_SPW * SW;
    localparam int CW = $clog2(P_SPW) + 1;
    localparam int FW = $clog2(P_FRAME_WDS) + 1;

    `MULAW_PACK_WORD_T(pack_word_t, DW)

    logic [SW-1:0]  acc_q [P_SPW];
    logic [SW-1:0]  acc_n [P_SPW];
    logic [CW-1:0]  cnt_q, cnt_n, fill;
    logic [FW-1:0]  wcnt_q, wcnt_n;
    mulaw_pack_st_e st_q, st_n;
    pack_word_t     word, head;
    logic           push, pop, drop;
    logic           fifo_full, fifo_empty;

    always_comb begin
        acc_n  = acc_q;
        fill   = cnt_q;
        wcnt_n = wcnt_q;
        st_n   = st_q;
        push   = 1'b0;
        word   = '0;
        if (i_enable) begin
            for (int i = 0; i < P_SPW; i++)
                if (cnt_q == CW'(i)) acc_n[i] = i_dt;
            fill = cnt_q + CW'(1);
        end
        // Slot 0 sits in the MSBs; slots beyond the fill level carry the idle code.
        for (int i = 0; i < P_SPW; i++)
            word.data[(P_SPW-1-i)*SW +: SW] = (CW'(i) < fill) ? acc_n[i] : P_IDLE_CODE;
        word.sof = (st_q == S_IDLE);
        word.eof = i_flush || (wcnt_q == FW'(P_FRAME_WDS-1));
        if (fill == CW'(P_SPW) || (i_flush && (fill != '0 || st_q == S_FILL)))
            push = 1'b1;
        cnt_n = push ? '0 : fill;
        if (push) begin
            if (word.eof) begin
                wcnt_n = '0;
                st_n   = S_IDLE;
            end else begin
                wcnt_n = wcnt_q + FW'(1);
                st_n   = S_FILL;
            end
        end
    end

    always_ff @(posedge i_clk) begin
        if (!i_rst_n) begin
            cnt_q  <= '0;
            wcnt_q <= '0;
            st_q   <= S_IDLE;
            o_ovf  <= 1'b0;
        end else begin
            cnt_q  <= cnt_n;
            wcnt_q <= wcnt_n;
            st_q   <= st_n;
            if (drop) o_ovf <= 1'b1;
        end
    end

    always_ff @(posedge i_clk) begin
        acc_q <= acc_n;
    end

`ifdef MULAW_PACK_DROP_CNT_EN
    always_ff @(posedge i_clk) begin
        if (!i_rst_n)
            o_drop_cnt <= '0;
        else if (drop && o_drop_cnt != 16'hFFFF)
            o_drop_cnt <= o_drop_cnt + 16'd1;
    end
`endif

    assign pop  = o_valid && i_ready;
    assign drop = push && fifo_full && !pop;

    mulaw_pack_fifo #(
        .P_W     ($bits(pack_word_t)),
        .P_DEPTH (P_FIFO_DEPTH)
    ) u_fifo (
        .i_clk   (i_clk),
        .i_rst_n (i_rst_n),
        .i_push  (push),
        .i_dt    (word),
        .i_pop   (pop),
        .o_dt    (head),
        .o_full  (fifo_full),
        .o_empty (fifo_empty)
    );

    // Outputs read as zero whenever nothing is presented, including straight out of reset.
    assign o_valid = !fifo_empty;
    assign o_dt    = o_valid ? head.data : '0;
    assign o_sof   = o_valid && head.sof;
    assign o_eof   = o_valid && head.eof;

endmodule

// File: tb/tb_mulaw_frame_packer.sv
// Scoreboard bench for mulaw_frame_packer: stimulus queues expected words, a negedge monitor checks them.
module tb_mulaw_frame_packer;

    logic        clk = 1'b0;
    logic        rst_n;
    logic [7:0]  dt;
    logic        en;
    logic        flush;
    logic        ready;
    logic [31:0] odt;
    logic        sof;
    logic        eof;
    logic        valid;
    logic        ovf;
`ifdef MULAW_PACK_DROP_CNT_EN
    logic [15:0] drop_cnt;
`endif

    int          checks = 0;
    int          errors = 0;
    logic [33:0] exp_q[$];
    int          bw = 0;
    logic        hold = 1'b0;
    logic [33:0] held = '0;

    always #5 clk = ~clk;

    mulaw_frame_packer dut (
        .i_clk      (clk),
        .i_rst_n    (rst_n),
        .i_dt       (dt),
        .i_enable   (en),
        .i_flush    (flush),
        .o_dt       (odt),
        .o_sof      (sof),
        .o_eof      (eof),
        .o_valid    (valid),
        .i_ready    (ready),
        .o_ovf      (ovf)
`ifdef MULAW_PACK_DROP_CNT_EN
        ,.o_drop_cnt (drop_cnt)
`endif
    );

    task automatic check(input string name, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%h exp=%h", name, got, exp);
        end
    endtask

    // Frame position of the next word: first word of a frame has sof, the 40th or a flushed one has eof.
    function automatic void expect_word(input logic [31:0] d, input logic force_eof, input logic keep);
        logic s, e;
        s  = (bw == 0);
        e  = force_eof || (bw == 39);
        bw = e ? 0 : bw + 1;
        if (keep) exp_q.push_back({s, e, d});
    endfunction

    task automatic cyc(input logic e, input logic [7:0] d, input logic f);
        en = e; dt = d; flush = f;
        @(posedge clk); #1;
        en = 1'b0; flush = 1'b0;
    endtask

    task automatic send_words(input int n, input logic [7:0] base, input int keep_n, input logic rnd_ready);
        for (int w = 0; w < n; w++) begin
            logic [31:0] d;
            d = '0;
            for (int s = 0; s < 4; s++) d = {d[23:0], 8'(base + 8'(4*w + s))};
            expect_word(d, 1'b0, w < keep_n);
            for (int s = 0; s < 4; s++) begin
                if (rnd_ready) ready = 1'($urandom_range(0, 1));
                cyc(1'b1, 8'(base + 8'(4*w + s)), 1'b0);
                if (rnd_ready) begin
                    ready = 1'($urandom_range(0, 1));
                    @(posedge clk); #1;
                end
            end
        end
    endtask

    task automatic drain(input string name);
        int n = 0;
        while ((exp_q.size() != 0 || valid) && n < 400) begin
            @(posedge clk); #1;
            n++;
        end
        check(name, 64'(exp_q.size() == 0 && !valid), 64'd1);
    endtask

    always @(negedge clk) begin
        if (!rst_n) begin
            hold = 1'b0;
        end else begin
            if (hold) check("stable", {valid, sof, eof, odt}, {1'b1, held});
            if (valid && ready) begin
                if (exp_q.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL unexpected_word got=%h exp=none", {sof, eof, odt});
                end else begin
                    check("word", {sof, eof, odt}, exp_q.pop_front());
                end
            end
            hold = valid && !ready;
            held = {sof, eof, odt};
        end
    end

    initial begin
        rst_n = 1'b0; en = 1'b0; dt = '0; flush = 1'b0; ready = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        check("rst_valid", 64'(valid), 64'd0);
        check("rst_sof",   64'(sof),   64'd0);
        check("rst_eof",   64'(eof),   64'd0);
        check("rst_dt",    64'(odt),   64'd0);
        check("rst_ovf",   64'(ovf),   64'd0);
        rst_n = 1'b1;
        ready = 1'b1;

        // Full frame 01..A0: 40 words, sof on the first, eof on the last.
        send_words(40, 8'h01, 40, 1'b0);
        drain("drain_frame");

        // Partial word closed by a separate flush cycle.
        cyc(1'b1, 8'h11, 1'b0);
        cyc(1'b1, 8'h22, 1'b0);
        cyc(1'b1, 8'h33, 1'b0);
        expect_word(32'h112233FF, 1'b1, 1'b1);
        cyc(1'b0, 8'h00, 1'b1);
        send_words(1, 8'h44, 1, 1'b0);
        // Flush on the sample that completes a word: one word only.
        cyc(1'b1, 8'h88, 1'b0);
        cyc(1'b1, 8'h99, 1'b0);
        cyc(1'b1, 8'hAA, 1'b0);
        expect_word(32'h8899AABB, 1'b1, 1'b1);
        cyc(1'b1, 8'hBB, 1'b1);
        drain("drain_flush");
        // Flush with nothing open is a no-op.
        cyc(1'b0, 8'h00, 1'b1);
        repeat (4) @(posedge clk);
        #1;
        check("idle_flush_valid", 64'(valid), 64'd0);
        // Flush arriving with the third sample of a word.
        cyc(1'b1, 8'h01, 1'b0);
        cyc(1'b1, 8'h02, 1'b0);
        expect_word(32'h010203FF, 1'b1, 1'b1);
        cyc(1'b1, 8'h03, 1'b1);
        drain("drain_same_cycle_flush");

        // Empty accumulator mid-frame -> one all-idle eof word, then a second flush does nothing.
        send_words(5, 8'h20, 5, 1'b0);
        expect_word(32'hFFFFFFFF, 1'b1, 1'b1);
        cyc(1'b0, 8'h00, 1'b1);
        drain("drain_empty_flush");
        cyc(1'b0, 8'h00, 1'b1);
        repeat (4) @(posedge clk);
        #1;
        check("idle_flush2_valid", 64'(valid), 64'd0);

        // Random backpressure; outputs must hold while stalled.
        send_words(12, 8'hB0, 12, 1'b1);
        expect_word(32'hFFFFFFFF, 1'b1, 1'b1);
        cyc(1'b0, 8'h00, 1'b1);
        ready = 1'b1;
        drain("drain_random_ready");
        check("no_ovf_yet", 64'(ovf), 64'd0);

        // Overflow: 40 words with the consumer stalled -> 8 kept, 32 dropped.
        ready = 1'b0;
        send_words(40, 8'h00, 8, 1'b0);
        check("ovf_valid", 64'(valid), 64'd1);
        check("ovf_sticky", 64'(ovf), 64'd1);
`ifdef MULAW_PACK_DROP_CNT_EN
        check("drop_cnt", 64'(drop_cnt), 64'd32);
`endif
        ready = 1'b1;
        drain("drain_overflow");
        check("ovf_still_set", 64'(ovf), 64'd1);

        // Reset with 2 buffered words and 2 pending samples discards everything.
        ready = 1'b0;
        send_words(2, 8'h40, 0, 1'b0);
        cyc(1'b1, 8'h50, 1'b0);
        cyc(1'b1, 8'h51, 1'b0);
        check("pre_rst_valid", 64'(valid), 64'd1);
        rst_n = 1'b0;
        @(posedge clk); #1;
        check("mid_rst_valid", 64'(valid), 64'd0);
        check("mid_rst_ovf", 64'(ovf), 64'd0);
        rst_n = 1'b1;
        bw = 0;
        ready = 1'b1;
        send_words(1, 8'h60, 1, 1'b0);
        drain("drain_post_reset");

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
